// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI initiator.
// Command encodings, frame widths and master FSM states.
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        SHIFT,
        WAIT,
        RECV,
        HOLD,
        GAP
    } state_e;

endpackage

// File: rtl/spi_master.sv
// SPI initiator: serialises 10-bit command frames on MOSI and
// returns the MISO byte for rd-data frames.
module spi_master #(
    parameter int RD_WAIT    = 3,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_data,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);
    import spi_pkg::*;

    localparam int WCW = $clog2(RD_WAIT + 1);
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  cmd_q, cmd_d;
    logic [3:0]          bit_q, bit_d;
    logic [WCW-1:0]      wait_q, wait_d;
    logic [GCW-1:0]      gap_q, gap_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rsp_q, rsp_d;
    logic                ss_n_q, ss_n_d;
    logic                mosi_q, mosi_d;
    logic                done_q, done_d;
    logic                rv_q, rv_d;
    logic                is_rd;

    assign is_rd = (cmd_q[9:8] == CMD_RD_DATA);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        rx_d    = rx_q;
        rsp_d   = rsp_q;
        ss_n_d  = ss_n_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        rv_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = CMD;
                    cmd_d   = cmd_data;
                    ss_n_d  = 1'b0;
                    mosi_d  = cmd_data[9];
                    rx_d    = '0;
                end
            end
            CMD: begin
                state_d = SHIFT;
                bit_d   = 4'd9;
                mosi_d  = cmd_q[9];
            end
            SHIFT: begin
                if (bit_q != 4'd0) begin
                    bit_d  = bit_q - 4'd1;
                    mosi_d = cmd_q[bit_q - 4'd1];
                end else begin
                    mosi_d = 1'b0;
                    if (is_rd) begin
                        state_d = WAIT;
                        wait_d  = WCW'(RD_WAIT - 1);
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    state_d = RECV;
                    bit_d   = 4'd7;
                end else begin
                    wait_d = wait_q - WCW'(1);
                end
            end
            RECV: begin
                rx_d = {rx_q[DATA_W-2:0], MISO};
                if (bit_q == 4'd0) begin
                    state_d = HOLD;
                end else begin
                    bit_d = bit_q - 4'd1;
                end
            end
            HOLD: begin
                ss_n_d = 1'b1;
                done_d = 1'b1;
                if (is_rd) begin
                    rv_d  = 1'b1;
                    rsp_d = rx_q;
                end
                // The IDLE cycle itself is the last SS_n-high gap cycle.
                if (GAP_CYCLES > 1) begin
                    state_d = GAP;
                    gap_d   = GCW'(GAP_CYCLES - 2);
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            bit_q   <= '0;
            wait_q  <= '0;
            gap_q   <= '0;
            rx_q    <= '0;
            rsp_q   <= '0;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            rx_q    <= rx_d;
            rsp_q   <= rsp_d;
            ss_n_q  <= ss_n_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            rv_q    <= rv_d;
        end
    end

    assign cmd_ready = rst_n && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign rsp_valid = rv_q;
    assign rsp_data  = rsp_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench: two spi_master instances (RD_WAIT 3 and 4), each
// paired with a behavioural SPI slave + RAM of matching read latency.
module tb_spi_master;

    logic       clk;
    logic       rst_n;
    logic [1:0] cmd_valid, cmd_ready, busy, done, rsp_valid;
    logic [1:0] ss_n, mosi, miso;
    logic [9:0] cmd_data [2];
    logic [7:0] rsp_data [2];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int RW = 3 + g;

        int         k;
        logic [9:0] rx;
        logic [9:0] rx_last;
        logic [7:0] waddr, raddr;
        logic [7:0] ram [256];

        spi_master #(.RD_WAIT(RW), .GAP_CYCLES(1)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cmd_valid (cmd_valid[g]),
            .cmd_data  (cmd_data[g]),
            .cmd_ready (cmd_ready[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_data  (rsp_data[g]),
            .SS_n      (ss_n[g]),
            .MOSI      (mosi[g]),
            .MISO      (miso[g])
        );

        // Slave: bit 0 is the check bit, bits 1..10 the command word.
        always @(posedge clk) begin
            if (!rst_n || ss_n[g]) begin
                k <= 0;
            end else begin
                k <= k + 1;
                if (k >= 1 && k <= 10) rx <= {rx[8:0], mosi[g]};
                if (k == 11) begin
                    rx_last <= rx;
                    case (rx[9:8])
                        2'b00:   waddr <= rx[7:0];
                        2'b01:   ram[waddr] <= rx[7:0];
                        2'b10:   raddr <= rx[7:0];
                        default: ;
                    endcase
                end
            end
        end

        assign miso[g] = (k >= 11 + RW && k < 19 + RW) ?
                         ram[raddr][18 + RW - k] : 1'b0;
    end

    int         cur_low = 0, last_low = 0;
    int         cur_high = 0, last_high = 0;
    logic [10:0] cur_seq = '0, last_seq = '0;
    logic       prev_ss = 1'b1;
    int         done_cnt = 0, rv_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!ss_n[0]) begin
            if (prev_ss) begin
                cur_low   = 0;
                cur_seq   = '0;
                last_high = cur_high;
            end
            if (cur_low < 11) cur_seq = {cur_seq[9:0], mosi[0]};
            cur_low++;
        end else begin
            if (!prev_ss) begin
                last_low = cur_low;
                last_seq = cur_seq;
                cur_high = 0;
            end
            cur_high++;
        end
        prev_ss = ss_n[0];
        if (done[0]) done_cnt++;
        if (rsp_valid[0]) begin
            rv_cnt++;
            chk("rv_with_done", done[0], 1);
        end
    end

    task automatic send(input int g, input logic [9:0] c);
        int n;
        @(negedge clk);
        cmd_valid[g] = 1'b1;
        cmd_data[g]  = c;
        n = 0;
        while (!cmd_ready[g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready[g]) chk("accept_timeout", cmd_ready[g], 1);
        @(negedge clk);
        cmd_valid[g] = 1'b0;
        cmd_data[g]  = 10'h3FF;
        chk("busy", busy[g], 1);
    endtask

    task automatic wait_done(input int g, input logic exp_rv);
        int n;
        n = 0;
        while (!done[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done", done[g], 1);
        chk("ss_up_at_done", ss_n[g], 1);
        chk("rsp_valid", rsp_valid[g], exp_rv);
        @(negedge clk);
        chk("done_pulse", done[g], 0);
    endtask

    task automatic xfer(input int g, input logic [9:0] c);
        send(g, c);
        wait_done(g, c[9:8] == 2'b11);
    endtask

    initial begin
        int dc, acc, dn, n;
        rst_n        = 1'b0;
        cmd_valid    = '0;
        cmd_data[0]  = '0;
        cmd_data[1]  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", ss_n[0], 1);
        chk("rst_mosi", mosi[0], 0);
        chk("rst_ready", cmd_ready[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_rv", rsp_valid[0], 0);
        chk("rst_rsp", rsp_data[0], 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready[0], 1);

        xfer(0, 10'h0A5);
        chk("wr_addr_mosi", last_seq, 11'h0A5);
        chk("wr_addr_low", last_low, 12);
        chk("wr_addr_rx", gen_dut[0].rx_last, 10'h0A5);

        // Abort a rd-data frame at SHIFT bit 4 (seventh SS_n-low cycle).
        dc = done_cnt;
        send(0, 10'h300);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ss_n", ss_n[0], 1);
        chk("abort_mosi", mosi[0], 0);
        chk("abort_done", done[0], 0);
        chk("abort_rv", rsp_valid[0], 0);
        chk("abort_rsp", rsp_data[0], 8'h00);
        chk("abort_ready", cmd_ready[0], 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt, dc);
        chk("abort_no_rv", rv_cnt, 0);

        dc = done_cnt;
        xfer(0, 10'h005);
        xfer(0, 10'h13C);
        chk("ram5", gen_dut[0].ram[5], 8'h3C);
        chk("wr_done_cnt", done_cnt - dc, 2);
        chk("wr_no_rv", rv_cnt, 0);

        xfer(0, 10'h205);
        xfer(0, 10'h300);
        chk("rd_rsp", rsp_data[0], 8'h3C);
        chk("rd_rv_cnt", rv_cnt, 1);
        chk("rd_low", last_low, 23);
        xfer(0, 10'h0A5);
        chk("rsp_hold", rsp_data[0], 8'h3C);
        chk("rv_cnt_hold", rv_cnt, 1);

        // Held request: one accept per frame, 1-cycle SS_n-high gaps.
        acc = 0;
        dn  = 0;
        n   = 0;
        @(negedge clk);
        cmd_valid[0] = 1'b1;
        cmd_data[0]  = 10'h0A5;
        while (dn < 3 && n < 300) begin
            if (cmd_ready[0]) acc++;
            @(negedge clk);
            n++;
            if (done[0]) dn++;
        end
        cmd_valid[0] = 1'b0;
        chk("held_done", dn, 3);
        chk("held_accepts", acc, 3);
        chk("held_gap", last_high, 1);
        chk("held_low", last_low, 12);
        repeat (3) @(negedge clk);
        chk("held_idle", busy[0], 0);

        xfer(1, 10'h007);
        xfer(1, 10'h1A5);
        xfer(1, 10'h207);
        xfer(1, 10'h300);
        chk("slow_ram_rsp", rsp_data[1], 8'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
